vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator and pixel output stage; next generation of the fixed 640x480 VGA driver.
- Generalised in resolution, porch/sync timing, sync polarity, colour width and pixel-clock divide.
- Exports pixel coordinates and a pixel request so upstream renderers fetch colour for a known (x,y).
- Sits between the framebuffer/renderer and the board DAC pins.

---
 rtl/vga_timing_gen.sv | 189 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a one-tick registered pixel output stage.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces the colour with 8 vertical bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int CLK_DIV  = 2
) (
  input  logic                                                clk,
  input  logic                                                reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                                                test_mode,
`endif
  input  logic [COLOR_W-1:0]                                  red,
  input  logic [COLOR_W-1:0]                                  green,
  input  logic [COLOR_W-1:0]                                  blue,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        pixel_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        pixel_y,
  output logic                                                pixel_req,
  output logic                                                line_start,
  output logic                                                frame_start,
  output logic [COLOR_W-1:0]                                  VGA_R,
  output logic [COLOR_W-1:0]                                  VGA_G,
  output logic [COLOR_W-1:0]                                  VGA_B,
  output logic                                                VGA_CLK,
  output logic                                                VGA_HS,
  output logic                                                VGA_VS,
  output logic                                                VGA_BLANK_N,
  output logic                                                VGA_SYNC_N
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int DW       = $clog2(CLK_DIV);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [DW-1:0]      div_q, div_d;
  logic [XW-1:0]      hCnt_q, hCnt_d;
  logic [YW-1:0]      vCnt_q, vCnt_d;
  logic               pixReq_q, pixReq_d;
  logic               lineStart_q, lineStart_d;
  logic               frameStart_q, frameStart_d;
  logic               vgaClk_q, vgaClk_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blankN_q, blankN_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic               tick;
  logic               curActive;
  logic [31:0]        hCur, vCur;
  logic [COLOR_W-1:0] srcR, srcG, srcB;

  assign tick      = (div_q == DIV_LAST);
  assign hCur      = 32'(hCnt_q);
  assign vCur      = 32'(vCnt_q);
  assign curActive = (hCur < H_ACTIVE) && (vCur < V_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [31:0] barIdx;
  logic [2:0]  barCode;

  // Bar code counts down from white at the left edge to black at the right edge.
  always_comb begin
    barIdx  = hCur / BAR_W;
    barCode = (barIdx > 32'd7) ? 3'd0 : 3'(32'd7 - barIdx);
    if (test_mode) begin
      srcR = {COLOR_W{barCode[2]}};
      srcG = {COLOR_W{barCode[1]}};
      srcB = {COLOR_W{barCode[0]}};
    end else begin
      srcR = red;
      srcG = green;
      srcB = blue;
    end
  end
`else
  assign srcR = red;
  assign srcG = green;
  assign srcB = blue;
`endif

  // Output stage samples the pre-increment coordinates, so it lags the counters by one tick.
  always_comb begin
    div_d        = tick ? '0 : div_q + DW'(1);
    hCnt_d       = hCnt_q;
    vCnt_d       = vCnt_q;
    pixReq_d     = pixReq_q;
    lineStart_d  = 1'b0;
    frameStart_d = 1'b0;
    hs_d         = hs_q;
    vs_d         = vs_q;
    blankN_d     = blankN_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    if (tick) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d      = '0;
        lineStart_d = 1'b1;
        if (vCnt_q == V_LAST) begin
          vCnt_d       = '0;
          frameStart_d = 1'b1;
        end else begin
          vCnt_d = vCnt_q + YW'(1);
        end
      end else begin
        hCnt_d = hCnt_q + XW'(1);
      end
      pixReq_d = (32'(hCnt_d) < H_ACTIVE) && (32'(vCnt_d) < V_ACTIVE);
      hs_d     = ((hCur >= HS_START) && (hCur < HS_END)) ? HS_ACT : ~HS_ACT;
      vs_d     = ((vCur >= VS_START) && (vCur < VS_END)) ? VS_ACT : ~VS_ACT;
      blankN_d = curActive;
      r_d      = curActive ? srcR : '0;
      g_d      = curActive ? srcG : '0;
      b_d      = curActive ? srcB : '0;
    end
    vgaClk_d = (div_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q        <= '0;
      hCnt_q       <= H_LAST;
      vCnt_q       <= V_LAST;
      pixReq_q     <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      vgaClk_q     <= 1'b0;
      hs_q         <= ~HS_ACT;
      vs_q         <= ~VS_ACT;
      blankN_q     <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
    end else begin
      div_q        <= div_d;
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      pixReq_q     <= pixReq_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
      vgaClk_q     <= vgaClk_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blankN_q     <= blankN_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  assign pixel_x     = hCnt_q;
  assign pixel_y     = vCnt_q;
  assign pixel_req   = pixReq_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_CLK     = vgaClk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blankN_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a small timing set so several full frames fit in the run.
// Expected values come from a tick-count model: position = (ticks since release - 1) mod frame size.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int HS_POL   = 1;
  localparam int VS_POL   = 1;
  localparam int COLOR_W  = 8;
  localparam int CLK_DIV  = 4;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);

  typedef struct {
    logic               hs;
    logic               vs;
    logic               blankN;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } expT;

  expT expQ[$];
  expT popped;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [COLOR_W-1:0] red = '0, green = '0, blue = '0;
  logic [XW-1:0]      pixel_x;
  logic [YW-1:0]      pixel_y;
  logic               pixel_req, line_start, frame_start;
  logic [COLOR_W-1:0] VGA_R, VGA_G, VGA_B;
  logic               VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

  int edgeCnt = 0;
  int nChecks = 0;
  int nPass   = 0;
  int mK, mD, mP, mX, mY;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(COLOR_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .red(red),
    .green(green),
    .blue(blue),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_req(pixel_req),
    .line_start(line_start),
    .frame_start(frame_start),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B),
    .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) edgeCnt <= 0;
    else        edgeCnt <= edgeCnt + 1;
  end

  function automatic int posOf(int k);
    return (k == 0) ? FRAME - 1 : (k - 1) % FRAME;
  endfunction

  function automatic logic isActive(int p);
    return ((p % H_TOTAL) < H_ACTIVE) && ((p / H_TOTAL) < V_ACTIVE);
  endfunction

  function automatic logic hsOf(int p);
    int x = p % H_TOTAL;
    logic inSync = (x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC);
    return inSync ? (HS_POL != 0) : (HS_POL == 0);
  endfunction

  function automatic logic vsOf(int p);
    int y = p / H_TOTAL;
    logic inSync = (y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC);
    return inSync ? (VS_POL != 0) : (VS_POL == 0);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // New colour for the coordinate just presented; it is displayed one tick later.
  task automatic applyStimulus();
    expT e;
    int p = posOf(edgeCnt / CLK_DIV);
    red   = COLOR_W'($urandom);
    green = COLOR_W'($urandom);
    blue  = COLOR_W'($urandom);
    e.hs     = hsOf(p);
    e.vs     = vsOf(p);
    e.blankN = isActive(p);
    e.r      = isActive(p) ? red   : '0;
    e.g      = isActive(p) ? green : '0;
    e.b      = isActive(p) ? blue  : '0;
    expQ.push_back(e);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
      if (edgeCnt % CLK_DIV == 0) applyStimulus();
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_pixel_x", int'(pixel_x), H_TOTAL - 1);
    checkOutput("rst_pixel_y", int'(pixel_y), V_TOTAL - 1);
    checkOutput("rst_pixel_req", int'(pixel_req), 0);
    checkOutput("rst_line_start", int'(line_start), 0);
    checkOutput("rst_frame_start", int'(frame_start), 0);
    checkOutput("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    checkOutput("rst_blank_n", int'(VGA_BLANK_N), 0);
    checkOutput("rst_hs", int'(VGA_HS), (HS_POL == 0) ? 1 : 0);
    checkOutput("rst_vs", int'(VGA_VS), (VS_POL == 0) ? 1 : 0);
    checkOutput("rst_vga_clk", int'(VGA_CLK), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    applyStimulus();
  endtask

  // Monitor: counters and pulses every clk, scoreboard pop on every pixel tick.
  always @(negedge clk) begin
    if (reset) begin
      mK = edgeCnt / CLK_DIV;
      mD = edgeCnt % CLK_DIV;
      mP = posOf(mK);
      mX = mP % H_TOTAL;
      mY = mP / H_TOTAL;
      checkOutput("pixel_x", int'(pixel_x), mX);
      checkOutput("pixel_y", int'(pixel_y), mY);
      checkOutput("pixel_req", int'(pixel_req), int'(isActive(mP)));
      checkOutput("vga_clk", int'(VGA_CLK), (mD >= CLK_DIV / 2) ? 1 : 0);
      checkOutput("line_start", int'(line_start), (mD == 0 && mK >= 1 && mX == 0) ? 1 : 0);
      checkOutput("frame_start", int'(frame_start), (mD == 0 && mK >= 1 && mP == 0) ? 1 : 0);
      checkOutput("sync_n", int'(VGA_SYNC_N), 0);
      if (mD == 0 && mK >= 1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL scoreboard: no expected entry at tick %0d", mK);
        end else begin
          popped = expQ.pop_front();
          checkOutput("vga_hs", int'(VGA_HS), int'(popped.hs));
          checkOutput("vga_vs", int'(VGA_VS), int'(popped.vs));
          checkOutput("vga_blank_n", int'(VGA_BLANK_N), int'(popped.blankN));
          checkOutput("vga_r", int'(VGA_R), int'(popped.r));
          checkOutput("vga_g", int'(VGA_G), int'(popped.g));
          checkOutput("vga_b", int'(VGA_B), int'(popped.b));
        end
      end
    end
  end

  initial begin
    int guard;
    #3;
    $display("[TB] power-up reset");
    doReset();
    runCycles(3 * FRAME * CLK_DIV + 10);

    // Abort in the middle of an HS pulse on a visible line.
    guard = 0;
    while (!((posOf(edgeCnt / CLK_DIV) % H_TOTAL) == H_ACTIVE + H_FP + 1 &&
             (posOf(edgeCnt / CLK_DIV) / H_TOTAL) == 1 &&
             (edgeCnt % CLK_DIV) == 1) && guard < 2000) begin
      runCycles(1);
      guard++;
    end
    if (guard >= 2000) begin
      nChecks++;
      $display("[TB] FAIL midframe_wait: reached %0d cycles, required < 2000", guard);
    end
    $display("[TB] mid-frame reset");
    doReset();
    runCycles(2 * FRAME * CLK_DIV + 10);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
